// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: shared state encodings and counter widths for the frame synchronizer
package frame_sync_pkg;
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;
endpackage

// File: rtl/frame_sync_controller_matcher.sv
// sync_word_matcher: serial shift register with a sync-word compare that includes the bit being accepted
module sync_word_matcher #(
  parameter int                  SYNC_LEN  = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1101
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic hit
);
  logic [SYNC_LEN-2:0] sr_q;
  logic [SYNC_LEN-1:0] win;
  assign win = {sr_q, din};
  assign hit = din_valid && (win == SYNC_WORD);
  // Only the newest SYNC_LEN-1 bits need storing; the incoming bit completes the window
  always_ff @(posedge clk)
    if (rst) sr_q <= '0;
    else if (din_valid) sr_q <= win[SYNC_LEN-2:0];
endmodule

// File: rtl/frame_sync_controller.sv
// frame_sync_controller: hunt/verify/lock frame synchronizer with flywheel; FRAME_SYNC_STATS_EN adds lock-loss and sync-miss counters
module frame_sync_controller
  import frame_sync_pkg::*;
#(
  parameter int                  SYNC_LEN    = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 4'b1101,
  parameter int                  FRAME_LEN   = 16,
  parameter int                  CONFIRM_CNT = 2,
  parameter int                  MISS_CNT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  output logic              locked,
  output logic              frame_start,
  output logic              payload_bit,
  output logic              payload_valid
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [STAT_W-1:0] lock_loss_cnt,
  output logic [STAT_W-1:0] sync_miss_cnt
`endif
);
  localparam int               POS_W   = $clog2(FRAME_LEN);
  localparam logic [POS_W-1:0] LAST    = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] PL_LAST = POS_W'(FRAME_LEN - SYNC_LEN - 1);
  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] good_q, good_d, miss_q, miss_d;
  logic             hit, last, miss_ev;
  logic             locked_q, frame_start_d, frame_start_q;
  logic             payload_bit_d, payload_bit_q, payload_valid_d, payload_valid_q;
  sync_word_matcher #(.SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD)) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .hit      (hit)
  );
  assign last = pos_q == LAST;
  // Next-state: frame position, confirmation and flywheel counters advance only on accepted bits
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    good_d  = good_q;
    miss_d  = miss_q;
    miss_ev = 1'b0;
    case (state_q)
      HUNT: if (hit) begin
        pos_d   = '0;
        good_d  = CNT_W'(1);
        state_d = VERIFY;
      end
      VERIFY: if (din_valid) begin
        pos_d = last ? '0 : pos_q + 1'b1;
        if (last) begin
          good_d  = good_q + 1'b1;
          miss_d  = '0;
          state_d = !hit ? HUNT : (good_d == CNT_W'(CONFIRM_CNT)) ? LOCKED : VERIFY;
        end
      end
      LOCKED: if (din_valid) begin
        pos_d = last ? '0 : pos_q + 1'b1;
        if (last) begin
          miss_ev = !hit;
          miss_d  = hit ? '0 : miss_q + 1'b1;
          state_d = (miss_ev && miss_d == CNT_W'(MISS_CNT)) ? HUNT : LOCKED;
        end
      end
      default: state_d = HUNT;
    endcase
  end
  assign payload_valid_d = din_valid && state_q == LOCKED && pos_q <= PL_LAST;
  assign payload_bit_d   = payload_valid_d && din;
  assign frame_start_d   = din_valid && last && state_d == LOCKED;
  // State and registered outputs; reset discards the bit accepted in the same cycle
  always_ff @(posedge clk)
    if (rst) begin
      state_q         <= HUNT;
      pos_q           <= '0;
      good_q          <= '0;
      miss_q          <= '0;
      locked_q        <= 1'b0;
      frame_start_q   <= 1'b0;
      payload_bit_q   <= 1'b0;
      payload_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pos_q           <= pos_d;
      good_q          <= good_d;
      miss_q          <= miss_d;
      locked_q        <= state_d == LOCKED;
      frame_start_q   <= frame_start_d;
      payload_bit_q   <= payload_bit_d;
      payload_valid_q <= payload_valid_d;
    end
  assign locked        = locked_q;
  assign frame_start   = frame_start_q;
  assign payload_bit   = payload_bit_q;
  assign payload_valid = payload_valid_q;
`ifdef FRAME_SYNC_STATS_EN
  logic [STAT_W-1:0] loss_q, loss_d, smiss_q, smiss_d;
  assign loss_d  = (state_q == LOCKED && state_d == HUNT && loss_q != '1) ? loss_q + 1'b1 : loss_q;
  assign smiss_d = (miss_ev && smiss_q != '1) ? smiss_q + 1'b1 : smiss_q;
  // Saturating statistics counters
  always_ff @(posedge clk)
    if (rst) begin
      loss_q  <= '0;
      smiss_q <= '0;
    end else begin
      loss_q  <= loss_d;
      smiss_q <= smiss_d;
    end
  assign lock_loss_cnt = loss_q;
  assign sync_miss_cnt = smiss_q;
`endif
endmodule

// File: tb/tb_frame_sync_controller.sv
// tb_frame_sync_controller: directed frame scenarios for the frame synchronizer
module tb_frame_sync_controller;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0, din_valid = 1'b0;
  logic locked, frame_start, payload_bit, payload_valid;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] lock_loss_cnt, sync_miss_cnt;
`endif
  int n_vec = 0, n_err = 0;
  int pv_n, gap_err;
  logic [11:0] got;
  logic fs_mid, fs_end, lk_pre, lk_end, lk_any;

  always #5 clk = ~clk;

  frame_sync_controller dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .locked       (locked),
    .frame_start  (frame_start),
    .payload_bit  (payload_bit),
    .payload_valid(payload_valid)
`ifdef FRAME_SYNC_STATS_EN
    ,
    .lock_loss_cnt(lock_loss_cnt),
    .sync_miss_cnt(sync_miss_cnt)
`endif
  );

  task automatic tick(input logic b, input logic v);
    din = b;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [11:0] pl, input logic [3:0] sw, input bit gaps,
                            output int pvn, output logic [11:0] g, output logic fsm,
                            output logic fse, output logic lkp, output logic lke,
                            output logic lka, output int gerr);
    logic [15:0] bits;
    bits = {pl, sw};
    pvn = 0; g = '0; fsm = 0; fse = 0; lkp = 0; lke = 0; lka = 0; gerr = 0;
    for (int k = 0; k < 16; k++) begin
      if (gaps)
        for (int j = 0; j < (k * 7 + 3) % 6; j++) begin
          tick(1'b1, 1'b0);
          if (payload_valid || frame_start || payload_bit || !locked) gerr++;
        end
      tick(bits[15-k], 1'b1);
      if (payload_valid) begin
        pvn++;
        g = {g[10:0], payload_bit};
      end
      if (frame_start) begin
        if (k == 15) fse = 1;
        else fsm = 1;
      end
      lka = lka | locked;
      if (k == 14) lkp = locked;
      if (k == 15) lke = locked;
    end
  endtask

  task automatic test_reset;
    rst = 1; din = 1; din_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    n_vec++; if (payload_valid !== 1'b0) begin n_err++; $display("FAIL reset_payload_valid got %b want 0", payload_valid); end
    n_vec++; if (payload_bit !== 1'b0) begin n_err++; $display("FAIL reset_payload_bit got %b want 0", payload_bit); end
`ifdef FRAME_SYNC_STATS_EN
    n_vec++; if (lock_loss_cnt !== 16'd0) begin n_err++; $display("FAIL reset_loss_cnt got %0d want 0", lock_loss_cnt); end
    n_vec++; if (sync_miss_cnt !== 16'd0) begin n_err++; $display("FAIL reset_miss_cnt got %0d want 0", sync_miss_cnt); end
`endif
    rst = 0;
  endtask

  task automatic test_clean_lock;
    send_frame(12'h000, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_any !== 1'b0) begin n_err++; $display("FAIL clean_first_frame_locked got %b want 0", lk_any); end
    send_frame(12'hA5C, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_pre !== 1'b0) begin n_err++; $display("FAIL clean_locked_early got %b want 0", lk_pre); end
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL clean_locked_rise got %b want 1", lk_end); end
    n_vec++; if (fs_end !== 1'b1) begin n_err++; $display("FAIL clean_lock_frame_start got %b want 1", fs_end); end
    n_vec++; if (pv_n !== 0) begin n_err++; $display("FAIL clean_verify_payload got %0d want 0", pv_n); end
    send_frame(12'h3C9, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (pv_n !== 12) begin n_err++; $display("FAIL clean_payload_count got %0d want 12", pv_n); end
    n_vec++; if (got !== 12'h3C9) begin n_err++; $display("FAIL clean_payload_bits got %h want 3c9", got); end
    n_vec++; if (fs_end !== 1'b1) begin n_err++; $display("FAIL clean_frame_start got %b want 1", fs_end); end
    n_vec++; if (fs_mid !== 1'b0) begin n_err++; $display("FAIL clean_frame_start_mid got %b want 0", fs_mid); end
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL clean_locked_hold got %b want 1", lk_end); end
  endtask

  task automatic test_flywheel;
    send_frame(12'h0F0, 4'b1001, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL fly_locked got %b want 1", lk_end); end
    n_vec++; if (fs_end !== 1'b1) begin n_err++; $display("FAIL fly_frame_start got %b want 1", fs_end); end
    n_vec++; if (got !== 12'h0F0) begin n_err++; $display("FAIL fly_payload_bits got %h want 0f0", got); end
    send_frame(12'h5A5, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (pv_n !== 12) begin n_err++; $display("FAIL fly_next_payload_count got %0d want 12", pv_n); end
    n_vec++; if (got !== 12'h5A5) begin n_err++; $display("FAIL fly_next_payload_bits got %h want 5a5", got); end
    send_frame(12'h111, 4'b1001, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    send_frame(12'h222, 4'b1001, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL fly_miss_cleared got %b want 1", lk_end); end
    send_frame(12'h333, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL fly_recover_locked got %b want 1", lk_end); end
`ifdef FRAME_SYNC_STATS_EN
    n_vec++; if (sync_miss_cnt !== 16'd3) begin n_err++; $display("FAIL fly_miss_cnt got %0d want 3", sync_miss_cnt); end
    n_vec++; if (lock_loss_cnt !== 16'd0) begin n_err++; $display("FAIL fly_loss_cnt got %0d want 0", lock_loss_cnt); end
`endif
  endtask

  task automatic test_gaps;
    send_frame(12'h9B3, 4'b1101, 1, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (gap_err !== 0) begin n_err++; $display("FAIL gaps_idle_outputs got %0d want 0", gap_err); end
    n_vec++; if (got !== 12'h9B3) begin n_err++; $display("FAIL gaps_payload_bits got %h want 9b3", got); end
    n_vec++; if (pv_n !== 12) begin n_err++; $display("FAIL gaps_payload_count got %0d want 12", pv_n); end
    send_frame(12'h1E7, 4'b1101, 1, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (gap_err !== 0) begin n_err++; $display("FAIL gaps2_idle_outputs got %0d want 0", gap_err); end
    n_vec++; if (got !== 12'h1E7) begin n_err++; $display("FAIL gaps2_payload_bits got %h want 1e7", got); end
    n_vec++; if (fs_end !== 1'b1 || fs_mid !== 1'b0) begin n_err++; $display("FAIL gaps_frame_start got end=%b mid=%b want end=1 mid=0", fs_end, fs_mid); end
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL gaps_locked got %b want 1", lk_end); end
  endtask

  task automatic test_loss;
    send_frame(12'h123, 4'b1001, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    send_frame(12'h456, 4'b1001, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_end !== 1'b1) begin n_err++; $display("FAIL loss_second_miss got %b want 1", lk_end); end
    send_frame(12'h789, 4'b1001, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_pre !== 1'b1) begin n_err++; $display("FAIL loss_locked_before got %b want 1", lk_pre); end
    n_vec++; if (lk_end !== 1'b0) begin n_err++; $display("FAIL loss_locked_fall got %b want 0", lk_end); end
    n_vec++; if (fs_end !== 1'b0) begin n_err++; $display("FAIL loss_frame_start got %b want 0", fs_end); end
    n_vec++; if (pv_n !== 12) begin n_err++; $display("FAIL loss_payload_count got %0d want 12", pv_n); end
`ifdef FRAME_SYNC_STATS_EN
    n_vec++; if (lock_loss_cnt !== 16'd1) begin n_err++; $display("FAIL loss_loss_cnt got %0d want 1", lock_loss_cnt); end
    n_vec++; if (sync_miss_cnt !== 16'd6) begin n_err++; $display("FAIL loss_miss_cnt got %0d want 6", sync_miss_cnt); end
`endif
  endtask

  task automatic test_false_sync;
    send_frame(12'h0D0, 4'b0000, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_any !== 1'b0) begin n_err++; $display("FAIL false_frame1_locked got %b want 0", lk_any); end
    send_frame(12'h000, 4'b0000, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_any !== 1'b0) begin n_err++; $display("FAIL false_frame2_locked got %b want 0", lk_any); end
    send_frame(12'h000, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_any !== 1'b0) begin n_err++; $display("FAIL false_rehunt_locked got %b want 0", lk_any); end
    send_frame(12'h000, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_pre !== 1'b0 || lk_end !== 1'b1) begin n_err++; $display("FAIL false_relock got pre=%b end=%b want pre=0 end=1", lk_pre, lk_end); end
  endtask

  task automatic test_reset_mid;
    tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1);
    tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1);
    n_vec++; if (payload_valid !== 1'b1 || payload_bit !== 1'b1) begin n_err++; $display("FAIL rmid_payload got v=%b b=%b want v=1 b=1", payload_valid, payload_bit); end
    rst = 1;
    tick(1'b1, 1'b1);
    rst = 0;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rmid_locked got %b want 0", locked); end
    n_vec++; if (payload_valid !== 1'b0) begin n_err++; $display("FAIL rmid_payload_valid got %b want 0", payload_valid); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rmid_frame_start got %b want 0", frame_start); end
`ifdef FRAME_SYNC_STATS_EN
    n_vec++; if (lock_loss_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_loss_cnt got %0d want 0", lock_loss_cnt); end
`endif
    send_frame(12'h000, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_any !== 1'b0) begin n_err++; $display("FAIL rmid_one_hit_locked got %b want 0", lk_any); end
    send_frame(12'hC33, 4'b1101, 0, pv_n, got, fs_mid, fs_end, lk_pre, lk_end, lk_any, gap_err);
    n_vec++; if (lk_pre !== 1'b0 || lk_end !== 1'b1) begin n_err++; $display("FAIL rmid_relock got pre=%b end=%b want pre=0 end=1", lk_pre, lk_end); end
  endtask

  initial begin
    test_reset;
    test_clean_lock;
    test_flywheel;
    test_gaps;
    test_loss;
    test_false_sync;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_sync_controller.md
# frame_sync_controller

Frame synchronizer that sequences a serial sync-word matcher over a framed bit stream. It hunts for the sync word, confirms it at the expected frame spacing, then holds lock with a flywheel that tolerates isolated corrupted sync words. It sits between the serial receive front end and the payload deframer. It emits lock status, a frame-start strobe and the payload bits of each frame.

## Interface
Parameters:
- SYNC_LEN, 4: sync word length in bits, 2..16.
- SYNC_WORD, 4'b1101: sync pattern, MSB received first. Must not be all-zeros.
- FRAME_LEN, 16: bits per frame including the sync word. Must satisfy FRAME_LEN > SYNC_LEN and FRAME_LEN ≤ 65535.
- CONFIRM_CNT, 2: consecutive correctly spaced sync hits required to lock, including the first. Range 2..15.
- MISS_CNT, 3: consecutive missed sync words that drop lock. Range 1..15.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 1: serial data bit.
- din_valid, input, 1: din is accepted on any rising edge where this is high.
- locked, output, 1: frame lock held.
- frame_start, output, 1: one-cycle strobe marking a frame boundary while locked.
- payload_bit, output, 1: payload data bit.
- payload_valid, output, 1: payload_bit is valid.

## Operation
- Matcher: an SYNC_LEN-bit shift register that shifts din in only when din_valid=1.
  - hit = din_valid && ({sr[SYNC_LEN-2:0], din} == SYNC_WORD). The hit therefore includes the bit currently being accepted.
- Bit index pos, width clog2(FRAME_LEN): the index of the accepted bit within the frame.
  - After a sync boundary, the next accepted bit has index 0.
  - Payload occupies indices 0..FRAME_LEN-SYNC_LEN-1.
  - The sync word occupies FRAME_LEN-SYNC_LEN..FRAME_LEN-1.
  - pos advances only on accepted bits and wraps FRAME_LEN-1 → 0.
- States: HUNT, VERIFY, LOCKED.
- HUNT:
  - pos is ignored.
  - On hit: pos←0, good←1, go to VERIFY.
- VERIFY:
  - Only the bit at pos==FRAME_LEN-1 is checked.
  - On hit: good←good+1. If good+1==CONFIRM_CNT, go to LOCKED and set miss←0.
  - On no hit at that position: go to HUNT immediately. The bit that just failed is not re-examined as a new hit candidate.
- LOCKED, checked only at pos==FRAME_LEN-1:
  - On hit: miss←0.
  - On no hit: miss←miss+1. If miss+1==MISS_CNT, go to HUNT. Otherwise stay LOCKED (flywheel).
- Boundary behaviour:
  - Sync words appearing at other positions are ignored in VERIFY and LOCKED.
  - din_valid=0: shift register, pos, counters and state all hold. Outputs go to their idle values.
  - rst during any state: next cycle is HUNT with all outputs 0 and the shift register cleared. Bits accepted in the reset cycle are discarded.

## Timing
- All outputs are registered, with 1-cycle latency from the accepting edge.
- Reset values: locked=0, frame_start=0, payload_bit=0, payload_valid=0.
- locked:
  - Rises the cycle after the confirming hit is accepted.
  - Falls the cycle after the MISS_CNT-th consecutive miss is accepted.
- frame_start:
  - High one cycle after an accepted pos==FRAME_LEN-1 bit whenever the block is LOCKED after that edge (hit or flywheel).
  - Also pulses on the VERIFY→LOCKED transition.
  - Never pulses on the transition to HUNT.
- payload_valid is high one cycle after each accepted bit with pos ≤ FRAME_LEN-SYNC_LEN-1 while in LOCKED. payload_bit carries that din.
- With continuous din_valid, payload_valid is high for FRAME_LEN-SYNC_LEN consecutive cycles per frame. frame_start immediately precedes the first of them.

## Configuration
- FRAME_SYNC_STATS_EN defined:
  - Adds output lock_loss_cnt[15:0], incremented on each LOCKED→HUNT transition.
  - Adds output sync_miss_cnt[15:0], incremented on each miss in LOCKED.
  - Both counters saturate at 16'hFFFF, clear on rst, and are registered alongside the other outputs.
- FRAME_SYNC_STATS_EN undefined: the ports and counters are absent, and core behaviour is identical.

## Structure
- Shared package/header frame_sync_pkg holds:
  - State encodings HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2. The 2'd3 encoding recovers to HUNT.
  - Counter width constants.
- Sub-module sync_word_matcher (parameters SYNC_LEN, SYNC_WORD; ports clk, rst, din, din_valid, hit) holds the shift register and the hit compare. The controller instantiates exactly one.

## Test plan
All tests use default parameters with continuous din_valid unless stated.
- Clean lock: send frames of 12 payload bits followed by 1101. locked rises 1 cycle after the 2nd sync word's last bit. frame_start and 12 payload_valid cycles follow per frame, with payload bits matching the stimulus.
- False sync: in HUNT, send 1101 inside payload with no sync 16 bits later. The block enters VERIFY, returns to HUNT at that check, and locked stays 0.
- Flywheel: while locked, corrupt one sync word to 1001. locked stays 1, frame_start still pulses, and payload continues. The next good sync clears miss.
- Loss: while locked, corrupt 3 consecutive sync words. locked falls 1 cycle after the 3rd corrupted word's last bit. With FRAME_SYNC_STATS_EN, lock_loss_cnt=1 and sync_miss_cnt=3.
- Gaps: in LOCKED, insert random din_valid=0 cycles (up to 5 long). Frame alignment, payload content and lock are all unchanged, and no output is valid during the gaps.
- Reset mid-payload while locked: locked, payload_valid and frame_start are 0 the next cycle. Re-lock requires 2 fresh sync hits.
